// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: register offsets, decoded
// register enum and small bus helpers.
package gpio_ctrl_pkg;

  localparam int GpioMaxWidth = 32;

  localparam logic [11:0] OffOut       = 12'h000;
  localparam logic [11:0] OffIn        = 12'h004;
  localparam logic [11:0] OffInDbnc    = 12'h008;
  localparam logic [11:0] OffOe        = 12'h00C;
  localparam logic [11:0] OffRiseEn    = 12'h010;
  localparam logic [11:0] OffFallEn    = 12'h014;
  localparam logic [11:0] OffStatus    = 12'h018;
  localparam logic [11:0] OffOutToggle = 12'h01C;

  typedef enum logic [3:0] {
    RegOut,
    RegIn,
    RegInDbnc,
    RegOe,
    RegRiseEn,
    RegFallEn,
    RegStatus,
    RegOutToggle,
    RegNone
  } gpio_reg_e;

  // Map the decoded part of the byte address onto a register; anything else
  // is unmapped.
  function automatic gpio_reg_e decode_reg(input logic [11:0] off);
    case (off)
      OffOut:       return RegOut;
      OffIn:        return RegIn;
      OffInDbnc:    return RegInDbnc;
      OffOe:        return RegOe;
      OffRiseEn:    return RegRiseEn;
      OffFallEn:    return RegFallEn;
      OffStatus:    return RegStatus;
      OffOutToggle: return RegOutToggle;
      default:      return RegNone;
    endcase
  endfunction

  // Expand the four byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_dbnc.sv
// One-bit debouncer: the output follows the synchronised input only after
// the input has differed from the output for DbncCount consecutive cycles.
module gpio_dbnc #(
  parameter int DbncCount = 500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync,
  output logic dbnc
);

  localparam int CntW = $clog2(DbncCount + 1);

  logic [CntW-1:0] cnt;

  // Count cycles of disagreement; any agreement restarts the count, so a
  // glitch shorter than DbncCount never reaches the output.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= '0;
      dbnc <= 1'b0;
    end else if (sync == dbnc) begin
      cnt <= '0;
    end else if (cnt == CntW'(DbncCount - 1)) begin
      cnt  <= '0;
      dbnc <= sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: pad output/enable registers, synchronised and debounced
// inputs, edge-triggered W1C status with a registered level interrupt, and
// a single-cycle-response device bus slave.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int Width     = 16,
  parameter int DbncCount = 500
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             device_req_i,
  input  logic [31:0]      device_addr_i,
  input  logic             device_we_i,
  input  logic [3:0]       device_be_i,
  input  logic [31:0]      device_wdata_i,
  output logic             device_rvalid_o,
  output logic [31:0]      device_rdata_o,
  input  logic [Width-1:0] gp_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] gp_oe_o,
  output logic             irq_o
);

  logic [Width-1:0] sync_meta, sync, dbnc, dbnc_q;
  logic [Width-1:0] out_q, oe_q, rise_en, fall_en, status;
  logic [Width-1:0] rise, fall, status_set, status_clr;
  logic [Width-1:0] wr_bits, be_bits;
  logic [31:0]      be_mask32, wr_data32;
  logic [GpioMaxWidth-1:0] rd_val;
  logic             wr;
  gpio_reg_e        reg_sel;

  // Address bits above the 4 KiB window and write-data bits above Width are
  // intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{device_addr_i[31:12], wr_data32, be_mask32};

  assign reg_sel   = decode_reg(device_addr_i[11:0]);
  assign wr        = device_req_i & device_we_i;
  assign be_mask32 = byte_mask(device_be_i);
  assign wr_data32 = device_wdata_i & be_mask32;
  assign be_bits   = be_mask32[Width-1:0];
  assign wr_bits   = wr_data32[Width-1:0];

  assign rise       = dbnc & ~dbnc_q;
  assign fall       = ~dbnc & dbnc_q;
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = (wr && reg_sel == RegStatus) ? wr_bits : '0;

  // Two-flop synchroniser for the asynchronous pads, then the edge-detect
  // delay flop behind the debouncers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_meta <= '0;
      sync      <= '0;
      dbnc_q    <= '0;
    end else begin
      sync_meta <= gp_i;
      sync      <= sync_meta;
      dbnc_q    <= dbnc;
    end
  end

  for (genvar i = 0; i < Width; i++) begin : g_dbnc
    gpio_dbnc #(
      .DbncCount(DbncCount)
    ) u_dbnc (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .sync  (sync[i]),
      .dbnc  (dbnc[i])
    );
  end

  // Software-writable control registers; writes land on the request edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q   <= '0;
      oe_q    <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr) begin
      case (reg_sel)
        RegOut:       out_q   <= (out_q & ~be_bits) | wr_bits;
        RegOutToggle: out_q   <= out_q ^ wr_bits;
        RegOe:        oe_q    <= (oe_q & ~be_bits) | wr_bits;
        RegRiseEn:    rise_en <= (rise_en & ~be_bits) | wr_bits;
        RegFallEn:    fall_en <= (fall_en & ~be_bits) | wr_bits;
        default:      ;
      endcase
    end
  end

  // Sticky edge status: set has priority over a simultaneous W1C clear;
  // the interrupt is a registered OR so no bus path reaches irq_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status <= '0;
      irq_o  <= 1'b0;
    end else begin
      status <= (status & ~status_clr) | status_set;
      irq_o  <= |status;
    end
  end

  // Read mux, zero-extended to the bus width.
  // NOTE: the default assignment up front keeps every path assigned so no
  // latch is inferred for unmapped or write-only offsets.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      RegOut:    rd_val[Width-1:0] = out_q;
      RegIn:     rd_val[Width-1:0] = sync;
      RegInDbnc: rd_val[Width-1:0] = dbnc;
      RegOe:     rd_val[Width-1:0] = oe_q;
      RegRiseEn: rd_val[Width-1:0] = rise_en;
      RegFallEn: rd_val[Width-1:0] = fall_en;
      RegStatus: rd_val[Width-1:0] = status;
      default:   ;
    endcase
  end

  // Response one cycle after every request; write responses carry zero and
  // idle cycles hold the last read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      if (device_req_i) begin
        device_rdata_o <= device_we_i ? '0 : rd_val;
      end
    end
  end

  assign gp_o    = out_q;
  assign gp_oe_o = oe_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (Width=16, DbncCount=4).
module tb_gpio_ctrl;

  localparam int W = 16;

  localparam logic [31:0] A_OUT  = 32'h00, A_IN   = 32'h04, A_DBNC = 32'h08;
  localparam logic [31:0] A_OE   = 32'h0C, A_RISE = 32'h10, A_FALL = 32'h14;
  localparam logic [31:0] A_STAT = 32'h18, A_TGL  = 32'h1C, A_UNM  = 32'h40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [31:0]   addr = '0;
  logic          we = 1'b0;
  logic [3:0]    be = '0;
  logic [31:0]   wdata = '0;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [W-1:0]  gp_in = '0;
  logic [W-1:0]  gp_out;
  logic [W-1:0]  gp_oe;
  logic          irq;

  int total = 0;
  int bad   = 0;

  gpio_ctrl #(
    .Width    (W),
    .DbncCount(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .gp_i           (gp_in),
    .gp_o           (gp_out),
    .gp_oe_o        (gp_oe),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge; return at the next negedge
  // with the response checked for rvalid.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] r);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(negedge clk);
    check("rvalid", {31'b0, rvalid}, 32'd1);
    r   = rdata;
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    bus(1'b1, a, d, b, r);
    check("wresp_zero", r, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'h0, 4'h0, r);
    check(tag, r, exp);
  endtask

  initial begin
    // Reset and idle state.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_gp_o", 32'(gp_out), 32'h0);
    check("rst_gp_oe", 32'(gp_oe), 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    for (int i = 0; i < 8; i++) rd_chk("rst_read", 32'(i * 4), 32'h0);
    @(negedge clk);
    check("idle_no_rvalid", {31'b0, rvalid}, 32'h0);

    // OUT byte masking and toggle.
    wr(A_OUT, 32'h0000A5A5, 4'b0001);
    check("gp_o_after_wr", 32'(gp_out), 32'h00A5);
    rd_chk("out_be", A_OUT, 32'h000000A5);
    @(negedge clk);
    check("rdata_hold", rdata, 32'h000000A5);
    wr(A_TGL, 32'h000000FF, 4'b1111);
    rd_chk("out_toggle", A_OUT, 32'h0000005A);
    rd_chk("toggle_reads0", A_TGL, 32'h0);

    // OE with bits above Width ignored.
    wr(A_OE, 32'hFFFFFFFF, 4'b1111);
    rd_chk("oe_width", A_OE, 32'h0000FFFF);
    check("gp_oe", 32'(gp_oe), 32'hFFFF);

    // Rising edge on pin 0 through synchroniser and debouncer.
    wr(A_RISE, 32'h1, 4'b0001);
    rd_chk("rise_en", A_RISE, 32'h1);
    gp_in[0] = 1'b1;
    rd_chk("in_k1", A_IN, 32'h0);
    rd_chk("in_k2", A_IN, 32'h0);
    rd_chk("in_k3", A_IN, 32'h1);
    rd_chk("dbnc_k4", A_DBNC, 32'h0);
    rd_chk("dbnc_k5", A_DBNC, 32'h0);
    rd_chk("dbnc_k6", A_DBNC, 32'h0);
    rd_chk("dbnc_k7", A_DBNC, 32'h1);
    check("irq_k7", {31'b0, irq}, 32'h0);
    rd_chk("status_k8", A_STAT, 32'h1);
    check("irq_k8", {31'b0, irq}, 32'h1);

    // Three-cycle glitch on pin 1 must be filtered out.
    wr(A_RISE, 32'h3, 4'b0001);
    wr(A_FALL, 32'h2, 4'b0001);
    gp_in[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) gp_in[1] = 1'b0;
      rd_chk("glitch_dbnc", A_DBNC, 32'h1);
    end
    rd_chk("glitch_status", A_STAT, 32'h1);

    // Pin 0 falls (fall disabled): status stays set.
    gp_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("irq_still_set", {31'b0, irq}, 32'h1);
    rd_chk("dbnc_fell", A_DBNC, 32'h0);

    // New rising edge arrives on the same edge as the W1C write: set wins.
    gp_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    wr(A_STAT, 32'h1, 4'b0001);
    rd_chk("set_wins", A_STAT, 32'h1);
    wr(A_STAT, 32'h1, 4'b0010);
    rd_chk("w1c_masked", A_STAT, 32'h1);
    wr(A_STAT, 32'h1, 4'b0001);
    rd_chk("w1c_clear", A_STAT, 32'h0);
    check("irq_dropped", {31'b0, irq}, 32'h0);

    // Unmapped and read-only writes are ignored.
    wr(A_UNM, 32'hFFFFFFFF, 4'b1111);
    rd_chk("unmapped", A_UNM, 32'h0);
    wr(A_IN, 32'hFFFFFFFF, 4'b1111);
    rd_chk("in_ro", A_IN, 32'h1);
    rd_chk("out_unchanged", A_OUT, 32'h0000005A);
    check("gp_o_unchanged", 32'(gp_out), 32'h005A);

    // Asynchronous reset with a request in flight.
    req  = 1'b1;
    addr = A_OUT;
    #2 rst_n = 1'b0;
    #1;
    check("async_gp_o", 32'(gp_out), 32'h0);
    check("async_gp_oe", 32'(gp_oe), 32'h0);
    @(negedge clk);
    check("rst_drop_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    req   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    rd_chk("post_rst_out", A_OUT, 32'h0);
    rd_chk("post_rst_rise", A_RISE, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised general-purpose I/O controller, successor to the fixed-direction GPIO peripheral. It provides per-pin output enable for bidirectional pads and a per-pin debounced input path. Rising/falling edge interrupts are latched in a write-1-to-clear status register, and a single level interrupt line goes to the interrupt controller. It sits on the device bus alongside the other memory-mapped peripherals, with one 4 KiB window.

## Interface
- `Width`, 16: number of GPIO pins, 1..32.
- `DbncCount`, 500: clock cycles an input must be stable before the debounced value follows it; ≥2.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `device_req_i`  in  1  bus request, single-cycle.
- `device_addr_i`  in  32  byte address; only [11:0] decoded.
- `device_we_i`  in  1  1 = write.
- `device_be_i`  in  4  byte enables for writes.
- `device_wdata_i`  in  32  write data.
- `device_rvalid_o`  out  1  response valid, one cycle after every request.
- `device_rdata_o`  out  32  read data, valid with `device_rvalid_o`.
- `gp_i`  in  Width  asynchronous pad inputs.
- `gp_o`  out  Width  pad output values.
- `gp_oe_o`  out  Width  pad output enables, 1 = drive.
- `irq_o`  out  1  level interrupt, high while any status bit is set.

## Operation
- Input path per pin: 2-flop synchroniser → `sync`; then debouncer → `dbnc`; then one delay flop `dbnc_q`.
- Edges: rise = `dbnc & ~dbnc_q`; fall = `~dbnc & dbnc_q`.
- Register map (offset, access, reset); bits ≥ Width read 0 and ignore writes:
  - 0x00 OUT, RW, 0: drives `gp_o`.
  - 0x04 IN, RO: `sync`.
  - 0x08 IN_DBNC, RO: `dbnc`.
  - 0x0C OE, RW, 0: drives `gp_oe_o`.
  - 0x10 RISE_EN, RW, 0.
  - 0x14 FALL_EN, RW, 0.
  - 0x18 STATUS, RW1C, 0.
  - 0x1C OUT_TOGGLE, WO, reads 0: each 1 bit written inverts the corresponding OUT bit.
- RW writes honour `device_be_i` per byte. W1C and toggle writes are also byte-masked.
- STATUS bit i is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- STATUS bit i is cleared by writing 1. Set and clear in the same cycle: set wins.
- Enable bits gate only the setting of STATUS; clearing an enable does not clear STATUS.
- Unmapped offsets: reads return 0, writes are ignored. Writes to RO registers are ignored.
- `irq_o` = |STATUS, driven from flops (no combinational path from the bus).

## Timing
- Reset values: `gp_o`, `gp_oe_o`, `irq_o`, `device_rvalid_o`, `device_rdata_o` all 0. Synchroniser, debouncer state, `dbnc_q` and STATUS are all 0.
- Every request (read or write) gets `device_rvalid_o` = 1 exactly one cycle later. There is no back-pressure. Back-to-back requests are supported every cycle.
- `device_rdata_o` is registered: it captures the addressed value at the request cycle and is presented at the rvalid cycle. After a write response it is 0; otherwise it holds its last value.
- Register writes take effect on the clock edge of the request; `gp_o` and `gp_oe_o` change that same edge.
- A read in the cycle after a write returns the new value.
- Input latency: a `gp_i` change is visible in IN after 2 cycles. It is visible in IN_DBNC after 2 + DbncCount cycles of stability.
- STATUS sets 1 cycle after the `dbnc` change. `irq_o` rises 1 cycle after STATUS sets.
- A glitch shorter than DbncCount cycles never changes `dbnc` and never sets STATUS.
- Asynchronous reset mid-operation returns all state to reset values immediately. Any in-flight response is dropped (no rvalid after reset).

## Structure
- Package `gpio_ctrl_pkg`:
  - offset localparams for all eight registers;
  - a `gpio_reg_e` enum for the decoded register;
  - `GpioMaxWidth = 32`.
- Sub-module `gpio_dbnc`: a one-bit debouncer with a `DbncCount` parameter and an internal counter of width $clog2(DbncCount+1). It is instantiated Width times via generate.
- Top level holds the synchroniser, edge detect, register file, decode and read mux.

## Test plan
- Width=16, DbncCount=4. Reset, then read all offsets → all return 0 and `gp_o`/`gp_oe_o`/`irq_o` = 0. Rvalid comes 1 cycle after each request.
- Write OUT=0xA5A5 with be=4'b0001, then read → 0x000000A5. Then write OUT_TOGGLE=0x00FF → OUT = 0x005A.
- Write RISE_EN=0x0001 and hold `gp_i[0]`=1 → IN bit0 = 1 after 2 cycles, IN_DBNC bit0 = 1 after 6 cycles, STATUS = 0x1 at cycle 7, `irq_o` = 1 at cycle 8.
- Pulse `gp_i[1]` high for 3 cycles with FALL_EN[1]=1 → IN_DBNC and STATUS stay 0 throughout.
- With STATUS bit0 set, write STATUS=0x1 in the same cycle a new enabled rising edge on pin 0 arrives → bit0 stays 1. A write on a later idle cycle clears it and `irq_o` drops.
- Write to offset 0x40 and to IN → no state change, both read back 0/unchanged. Assert `rst_ni` low mid-transfer → all outputs return to 0 and no rvalid follows.
